// File: rtl/multicycle_control_fsm.sv
// Multi-cycle MIPS control sequencer (FETCH/DECODE/EXEC/MEM/WB).
// Build option: define CU_ILLEGAL_TRAP_EN to park unsupported ops in TRAP.
module multicycle_control_fsm #(
  parameter int ALUOP_W     = 2,
  parameter int MEM_TIMEOUT = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [5:0]         opcode,
  input  logic [5:0]         funct,
  input  logic [4:0]         rt_field,
  input  logic               mem_ready,
  output logic               mem_req,
  output logic               mem_we,
  output logic               i_or_d,
  output logic               ir_write,
  output logic               pc_write,
  output logic               pc_write_cond,
  output logic [1:0]         pc_src,
  output logic               alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic [ALUOP_W-1:0] alu_op,
  output logic               reg_write,
  output logic [1:0]         reg_dst,
  output logic [1:0]         wb_sel,
  output logic [3:0]         state_o,
  output logic               mem_timeout,
  output logic               illegal_op
);

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    EXEC_R   = 4'd2,
    EXEC_I   = 4'd3,
    MEM_ADDR = 4'd4,
    MEM_RD   = 4'd5,
    MEM_WR   = 4'd6,
    WB_ALU   = 4'd7,
    WB_MEM   = 4'd8,
    BRANCH   = 4'd9,
    JUMP     = 4'd10,
    TRAP     = 4'd11
  } state_t;

  typedef enum logic [3:0] {
    C_ILL, C_R, C_JR, C_JALR,
    C_ADDIU, C_IALU, C_LOAD, C_STORE,
    C_BEQ, C_BCMP, C_J, C_JAL
  } cls_t;

  typedef struct packed {
    logic       fetch;
    logic       req;
    logic       we;
    logic       iod;
    logic       pcw;
    logic       pcwc;
    logic [1:0] psrc;
    logic       asa;
    logic [1:0] asb;
    logic [1:0] aop;
    logic       rw;
    logic [1:0] rdst;
    logic [1:0] wsel;
  } ctl_t;

  localparam int WW = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WW-1:0] WMAX = WW'(MEM_TIMEOUT);

  state_t        state;
  state_t        nxt;
  cls_t          cls;
  cls_t          ncls;
  cls_t          dcls;
  ctl_t          ctl;
  logic [WW-1:0] wcnt;

  function automatic cls_t decode(
    input logic [5:0] op,
    input logic [5:0] fn,
    input logic [4:0] rt
  );
    cls_t c;
    c = C_ILL;
    unique case (op)
      6'b000000: begin
        unique case (fn)
          6'b001000: c = C_JR;
          6'b001001: c = C_JALR;
          6'b000000, 6'b000010, 6'b000011,
          6'b000100, 6'b000110, 6'b000111,
          6'b100000, 6'b100001, 6'b100010,
          6'b100011, 6'b100100, 6'b100101,
          6'b100110, 6'b100111, 6'b101010,
          6'b101011: c = C_R;
          default:   c = C_ILL;
        endcase
      end
      6'b000001: begin
        if (rt == 5'b10001 || rt == 5'b00000)
          c = C_BCMP;
      end
      6'b000010: c = C_J;
      6'b000011: c = C_JAL;
      6'b000100, 6'b000101: c = C_BEQ;
      6'b000110, 6'b000111: c = C_BCMP;
      6'b001001: c = C_ADDIU;
      6'b001010, 6'b001011, 6'b001100,
      6'b001101, 6'b001110, 6'b001111: c = C_IALU;
      6'b100000, 6'b100001, 6'b100010,
      6'b100011, 6'b100100, 6'b100101,
      6'b100110: c = C_LOAD;
      6'b101000, 6'b101001, 6'b101010,
      6'b101011, 6'b101110: c = C_STORE;
      default: c = C_ILL;
    endcase
    return c;
  endfunction

  function automatic ctl_t outs(input state_t s, input cls_t c);
    ctl_t o;
    o = '0;
    unique case (s)
      FETCH: begin
        o.fetch = 1'b1;
        o.req   = 1'b1;
        o.asb   = 2'd1;
      end
      DECODE: o.asb = 2'd3;
      EXEC_R: begin
        o.asa = 1'b1;
        o.aop = 2'b10;
      end
      EXEC_I: begin
        o.asa = 1'b1;
        o.asb = 2'd2;
        o.aop = (c == C_ADDIU) ? 2'b00 : 2'b11;
      end
      MEM_ADDR: begin
        o.asa = 1'b1;
        o.asb = 2'd2;
      end
      MEM_RD: begin
        o.req = 1'b1;
        o.iod = 1'b1;
      end
      MEM_WR: begin
        o.req = 1'b1;
        o.iod = 1'b1;
        o.we  = 1'b1;
      end
      WB_ALU: begin
        o.rw   = 1'b1;
        o.rdst = (c == C_R) ? 2'd1 : 2'd0;
      end
      WB_MEM: begin
        o.rw   = 1'b1;
        o.wsel = 2'd1;
      end
      BRANCH: begin
        o.asa  = 1'b1;
        o.aop  = (c == C_BEQ) ? 2'b01 : 2'b11;
        o.pcwc = 1'b1;
        o.psrc = 2'd1;
      end
      JUMP: begin
        o.pcw  = 1'b1;
        o.psrc = (c == C_JR || c == C_JALR)
               ? 2'd3 : 2'd2;
        if (c == C_JAL || c == C_JALR) begin
          o.rw   = 1'b1;
          o.wsel = 2'd2;
          o.rdst = (c == C_JAL) ? 2'd2 : 2'd1;
        end
      end
      default: o = '0;
    endcase
    return o;
  endfunction

  assign dcls = decode(opcode, funct, rt_field);

  always_comb begin
    nxt  = state;
    ncls = cls;
    unique case (state)
      FETCH: if (ctl.req && mem_ready) nxt = DECODE;
      DECODE: begin
        ncls = dcls;
        unique case (dcls)
          C_R:                      nxt = EXEC_R;
          C_JR, C_JALR, C_J, C_JAL: nxt = JUMP;
          C_ADDIU, C_IALU:          nxt = EXEC_I;
          C_LOAD, C_STORE:          nxt = MEM_ADDR;
          C_BEQ, C_BCMP:            nxt = BRANCH;
`ifdef CU_ILLEGAL_TRAP_EN
          default:                  nxt = TRAP;
`else
          default:                  nxt = FETCH;
`endif
        endcase
      end
      EXEC_R, EXEC_I: nxt = WB_ALU;
      MEM_ADDR: nxt = (cls == C_LOAD) ? MEM_RD : MEM_WR;
      MEM_RD: if (mem_ready) nxt = WB_MEM;
      MEM_WR: if (mem_ready) nxt = FETCH;
      TRAP:   nxt = TRAP;
      default: nxt = FETCH;
    endcase
  end

  // control word is registered for the state being entered
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= FETCH;
      cls         <= C_ILL;
      ctl         <= '0;
      wcnt        <= '0;
      mem_timeout <= 1'b0;
    end else begin
      state <= nxt;
      cls   <= ncls;
      ctl   <= outs(nxt, ncls);
      if (!ctl.req || mem_ready)
        wcnt <= '0;
      else if (wcnt != WMAX)
        wcnt <= wcnt + 1'b1;
      if (ctl.req && !mem_ready &&
          wcnt == WMAX - 1'b1)
        mem_timeout <= 1'b1;
    end
  end

  assign mem_req       = ctl.req;
  assign mem_we        = ctl.we;
  assign i_or_d        = ctl.iod;
  assign ir_write      = ctl.fetch & mem_ready;
  assign pc_write      = ctl.pcw |
                         (ctl.fetch & mem_ready);
  assign pc_write_cond = ctl.pcwc;
  assign pc_src        = ctl.psrc;
  assign alu_src_a     = ctl.asa;
  assign alu_src_b     = ctl.asb;
  assign alu_op        = ALUOP_W'(ctl.aop);
  assign reg_write     = ctl.rw;
  assign reg_dst       = ctl.rdst;
  assign wb_sel        = ctl.wsel;
  assign state_o       = state;
  assign illegal_op    = (state == DECODE) &&
                         (dcls == C_ILL);

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Bench for multicycle_control_fsm: directed plus random instruction
// stream, expected per-cycle controls queued and checked by a monitor.
module tb_multicycle_control_fsm;

  typedef struct packed {
    logic [3:0] st;
    logic       req;
    logic       we;
    logic       iod;
    logic       irw;
    logic       pcw;
    logic       pcwc;
    logic [1:0] psrc;
    logic       asa;
    logic [1:0] asb;
    logic [1:0] aop;
    logic       rw;
    logic [1:0] rdst;
    logic [1:0] wsel;
    logic       ill;
    logic       tmo;
  } obs_t;

  typedef enum int {
    K_ILL, K_R, K_JR, K_JALR, K_ADDIU, K_IALU,
    K_LD, K_ST, K_BEQ, K_BZ, K_J, K_JAL
  } kind_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [5:0] opcode = '0;
  logic [5:0] funct = '0;
  logic [4:0] rt_field = '0;
  logic       mem_ready = 1'b0;
  logic       mem_req, mem_we, i_or_d, ir_write;
  logic       pc_write, pc_write_cond;
  logic [1:0] pc_src, alu_src_b, alu_op;
  logic       alu_src_a, reg_write;
  logic [1:0] reg_dst, wb_sel;
  logic [3:0] state_o;
  logic       mem_timeout, illegal_op;

  always #5 clk = ~clk;

  multicycle_control_fsm dut (
    .clk(clk), .rst(rst),
    .opcode(opcode), .funct(funct),
    .rt_field(rt_field), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_we(mem_we),
    .i_or_d(i_or_d), .ir_write(ir_write),
    .pc_write(pc_write),
    .pc_write_cond(pc_write_cond),
    .pc_src(pc_src), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .alu_op(alu_op),
    .reg_write(reg_write), .reg_dst(reg_dst),
    .wb_sel(wb_sel), .state_o(state_o),
    .mem_timeout(mem_timeout),
    .illegal_op(illegal_op)
  );

  obs_t       exp_q[$];
  int         n_chk = 0;
  int         n_fail = 0;
  int         n_cyc = 0;
  int         m_wait = 0;
  bit         m_tmo = 1'b0;
  logic [5:0] cur_op = '0;
  logic [5:0] cur_fn = '0;
  logic [4:0] cur_rt = '0;

  logic [5:0] vops [16] = '{
    6'h00, 6'h00, 6'h01, 6'h02, 6'h03, 6'h04,
    6'h05, 6'h06, 6'h07, 6'h09, 6'h0f, 6'h0c,
    6'h23, 6'h20, 6'h2b, 6'h28};
  logic [5:0] vfn [6] = '{
    6'h21, 6'h08, 6'h09, 6'h2a, 6'h00, 6'h27};

  // supported instruction set, straight from the opcode tables
  function automatic kind_t kind_of(
    input logic [5:0] op,
    input logic [5:0] fn,
    input logic [4:0] rt
  );
    if (op == 6'h00) begin
      if (fn == 6'h08) return K_JR;
      if (fn == 6'h09) return K_JALR;
      if (fn inside {6'h00, 6'h02, 6'h03, 6'h04,
                     6'h06, 6'h07, [6'h20:6'h27],
                     6'h2a, 6'h2b})
        return K_R;
      return K_ILL;
    end
    if (op == 6'h01)
      return (rt inside {5'b10001, 5'b00000})
             ? K_BZ : K_ILL;
    if (op == 6'h02) return K_J;
    if (op == 6'h03) return K_JAL;
    if (op inside {6'h04, 6'h05}) return K_BEQ;
    if (op inside {6'h06, 6'h07}) return K_BZ;
    if (op == 6'h09) return K_ADDIU;
    if (op inside {[6'h0a:6'h0f]}) return K_IALU;
    if (op inside {[6'h20:6'h26]}) return K_LD;
    if (op inside {6'h28, 6'h29, 6'h2a, 6'h2b, 6'h2e})
      return K_ST;
    return K_ILL;
  endfunction

  function automatic obs_t ob(input logic [3:0] st);
    obs_t o;
    o = '0;
    o.st = st;
    return o;
  endfunction

  function automatic obs_t sample();
    obs_t g;
    g.st   = state_o;
    g.req  = mem_req;
    g.we   = mem_we;
    g.iod  = i_or_d;
    g.irw  = ir_write;
    g.pcw  = pc_write;
    g.pcwc = pc_write_cond;
    g.psrc = pc_src;
    g.asa  = alu_src_a;
    g.asb  = alu_src_b;
    g.aop  = alu_op;
    g.rw   = reg_write;
    g.rdst = reg_dst;
    g.wsel = wb_sel;
    g.ill  = illegal_op;
    g.tmo  = mem_timeout;
    return g;
  endfunction

  function automatic bit noise();
    return bit'($urandom_range(0, 1));
  endfunction

  // one clock: expected outputs for this cycle, inputs for the next edge
  task automatic cyc(input obs_t e, input bit rdy, input bit r);
    @(posedge clk);
    #1;
    e.tmo = m_tmo;
    exp_q.push_back(e);
    mem_ready = rdy;
    rst       = r;
    opcode    = cur_op;
    funct     = cur_fn;
    rt_field  = cur_rt;
    if (e.req && !rdy) begin
      m_wait++;
      if (m_wait == 16) m_tmo = 1'b1;
    end else begin
      m_wait = 0;
    end
    if (r) begin
      m_wait = 0;
      m_tmo  = 1'b0;
    end
  endtask

  task automatic run(
    input logic [5:0] op,
    input logic [5:0] fn,
    input logic [4:0] rt,
    input int fw,
    input int mw,
    input int rst_at
  );
    kind_t k;
    obs_t  o;
    k = kind_of(op, fn, rt);
    cur_op = op;
    cur_fn = fn;
    cur_rt = rt;
    o = ob(4'd0);
    o.req = 1'b1;
    o.asb = 2'd1;
    for (int i = 0; i < fw; i++) cyc(o, 1'b0, 1'b0);
    o.irw = 1'b1;
    o.pcw = 1'b1;
    cyc(o, 1'b1, 1'b0);
    o = ob(4'd1);
    o.asb = 2'd3;
    o.ill = (k == K_ILL);
    cyc(o, noise(), 1'b0);
    case (k)
      K_R: begin
        o = ob(4'd2);
        o.asa = 1'b1;
        o.aop = 2'b10;
        cyc(o, noise(), 1'b0);
        o = ob(4'd7);
        o.rw = 1'b1;
        o.rdst = 2'd1;
        cyc(o, noise(), 1'b0);
      end
      K_ADDIU, K_IALU: begin
        o = ob(4'd3);
        o.asa = 1'b1;
        o.asb = 2'd2;
        o.aop = (k == K_ADDIU) ? 2'b00 : 2'b11;
        cyc(o, noise(), 1'b0);
        o = ob(4'd7);
        o.rw = 1'b1;
        cyc(o, noise(), 1'b0);
      end
      K_LD, K_ST: begin
        o = ob(4'd4);
        o.asa = 1'b1;
        o.asb = 2'd2;
        cyc(o, noise(), 1'b0);
        o = ob((k == K_LD) ? 4'd5 : 4'd6);
        o.req = 1'b1;
        o.iod = 1'b1;
        o.we  = (k == K_ST);
        for (int i = 0; i < mw; i++) begin
          cyc(o, 1'b0, i == rst_at);
          if (i == rst_at) begin
            cyc(ob(4'd0), noise(), 1'b0);
            return;
          end
        end
        cyc(o, 1'b1, 1'b0);
        if (k == K_LD) begin
          o = ob(4'd8);
          o.rw = 1'b1;
          o.wsel = 2'd1;
          cyc(o, noise(), 1'b0);
        end
      end
      K_BEQ, K_BZ: begin
        o = ob(4'd9);
        o.asa = 1'b1;
        o.aop = (k == K_BEQ) ? 2'b01 : 2'b11;
        o.pcwc = 1'b1;
        o.psrc = 2'd1;
        cyc(o, noise(), 1'b0);
      end
      K_J, K_JAL, K_JR, K_JALR: begin
        o = ob(4'd10);
        o.pcw = 1'b1;
        o.psrc = (k == K_JR || k == K_JALR) ? 2'd3 : 2'd2;
        if (k == K_JAL || k == K_JALR) begin
          o.rw = 1'b1;
          o.wsel = 2'd2;
          o.rdst = (k == K_JAL) ? 2'd2 : 2'd1;
        end
        cyc(o, noise(), 1'b0);
      end
      default: begin
`ifdef CU_ILLEGAL_TRAP_EN
        cyc(ob(4'd11), noise(), 1'b0);
        cyc(ob(4'd11), noise(), 1'b0);
        cyc(ob(4'd11), noise(), 1'b1);
        cyc(ob(4'd0), noise(), 1'b0);
`endif
      end
    endcase
  endtask

  initial begin
    obs_t e;
    obs_t g;
    forever begin
      @(negedge clk);
      n_cyc++;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        g = sample();
        n_chk++;
        if (g !== e) begin
          n_fail++;
          $display("FAIL ctl cycle %0d: state got %0d req %0d, got %h, required %h",
                   n_cyc, g.st, e.st, g, e);
        end
      end
    end
  end

  initial begin
    logic [5:0] op;
    logic [5:0] fn;
    logic [4:0] rt;
    rst = 1'b1;
    @(posedge clk);
    #1;
    cyc(ob(4'd0), 1'b0, 1'b0);
    run(6'h00, 6'h21, 5'h00, 0, 0, -1);
    run(6'h23, 6'h00, 5'h00, 1, 3, -1);
    run(6'h01, 6'h00, 5'b10001, 0, 0, -1);
    run(6'h01, 6'h00, 5'b00011, 0, 0, -1);
    run(6'h03, 6'h00, 5'h00, 0, 0, -1);
    run(6'h00, 6'h09, 5'h00, 2, 0, -1);
    run(6'h00, 6'h08, 5'h00, 0, 0, -1);
    run(6'h09, 6'h00, 5'h00, 0, 0, -1);
    run(6'h0f, 6'h00, 5'h00, 0, 0, -1);
    run(6'h05, 6'h00, 5'h00, 0, 0, -1);
    run(6'h2b, 6'h00, 5'h00, 0, 20, -1);
    run(6'h00, 6'h21, 5'h00, 0, 0, -1);
    run(6'h3f, 6'h3f, 5'h1f, 0, 0, -1);
    run(6'h2b, 6'h00, 5'h00, 0, 4, 1);
    run(6'h02, 6'h00, 5'h00, 0, 0, -1);
    for (int n = 0; n < 200; n++) begin
      op = 6'($urandom);
      if ($urandom_range(0, 3) != 0)
        op = vops[$urandom_range(0, 15)];
      fn = 6'($urandom);
      if (op == 6'h00 && $urandom_range(0, 3) != 0)
        fn = vfn[$urandom_range(0, 5)];
      rt = 5'($urandom);
      if (op == 6'h01 && $urandom_range(0, 2) != 0)
        rt = ($urandom_range(0, 1) != 0) ? 5'b10001 : 5'b00000;
      run(op, fn, rt, $urandom_range(0, 3),
          $urandom_range(0, 3), -1);
    end
    repeat (3) @(negedge clk);
    n_chk++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d entries left, required 0",
               exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
